// File: rtl/divisor_clock_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DEFAULT_HALF_FPGA  default half-period terminal count (25000 -> 25001 clocks)
//   DIV_WIDTH_DEFAULT  default counter width
//   ch_width(n)        channel-index width, never below 1 bit
//   ch_action_e        per-channel action chosen each clock, in priority order
package divisor_clock_pkg;

  localparam int unsigned DEFAULT_HALF_FPGA = 25000;
  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CH_RESTART,
    CH_HOLD,
    CH_TERMINAL,
    CH_COUNT
  } ch_action_e;

endpackage

// File: rtl/divisor_clock_channel.sv
// One divider channel: half-period counter, active terminal count, shadow
// register with pending flag, divided clock and toggle strobe.
//   clock      in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable
//   restart    in   synchronous restart (overrides en and terminal count)
//   wr         in   shadow write strobe
//   wr_half    in   value written into the shadow
//   clock_div  out  divided clock (registered)
//   tick       out  high in the cycle clock_div changes
//   pending    out  shadow holds a value not yet applied
module divisor_clock_channel
  import divisor_clock_pkg::*;
#(
  parameter int unsigned WIDTH        = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_FPGA
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_half,
  output logic             clock_div,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  ch_action_e       action;

  always_comb begin
    if (restart)                 action = CH_RESTART;
    else if (!en)                action = CH_HOLD;
    else if (cnt_q == active_q)  action = CH_TERMINAL;
    else                         action = CH_COUNT;
  end

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    div_d     = div_q;
    tick_d    = 1'b0;

    unique case (action)
      CH_RESTART: begin
        cnt_d = '0;
        div_d = 1'b0;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end
      CH_HOLD: ;
      CH_TERMINAL: begin
        cnt_d  = '0;
        div_d  = ~div_q;
        tick_d = 1'b1;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end
      CH_COUNT: cnt_d = cnt_q + WIDTH'(1);
      default: ;
    endcase

    // A write after the apply above: the old shadow is consumed this edge,
    // the new one stays pending for the next terminal count or restart.
    if (wr) begin
      shadow_d  = wr_half;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      active_q  <= WIDTH'(DEFAULT_HALF);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  assign clock_div = div_q;
  assign tick      = tick_q;
  assign pending   = pending_q;

endmodule

// File: rtl/divisor_clock_multi.sv
// Multi-channel programmable clock divider. Each channel produces a 50% duty
// divided clock and a toggle strobe; half-periods are reprogrammed through a
// shadowed config port applied only at a terminal count or a sync restart.
//   clock         in   system clock
//   rst_n         in   asynchronous active-low reset
//   cfg_we        in   write strobe for cfg_half into shadow of cfg_ch
//   cfg_ch        in   target channel (values >= CHANNELS ignored)
//   cfg_half      in   terminal count T (half-period = T+1 clocks)
//   enable        in   per-channel run enable
//   sync_restart  in   restart all channels in phase
//   clock_div     out  divided clocks
//   tick          out  per-channel toggle strobes
//   pending       out  per-channel unapplied-shadow flags
module divisor_clock_multi
  import divisor_clock_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_FPGA,
  localparam int unsigned CH_W        = ch_width(CHANNELS)
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_half,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] clock_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] wr;

  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    divisor_clock_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clock     (clock),
      .rst_n     (rst_n),
      .en        (enable[g]),
      .restart   (sync_restart),
      .wr        (wr[g]),
      .wr_half   (cfg_half),
      .clock_div (clock_div[g]),
      .tick      (tick[g]),
      .pending   (pending[g])
    );
  end

endmodule

// File: tb/tb_divisor_clock_multi.sv
module tb_divisor_clock_multi;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_half;
  logic [3:0]  enable;
  logic        sync_restart;
  logic [3:0]  clock_div;
  logic [3:0]  tick;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  divisor_clock_multi #(
    .CHANNELS     (4),
    .WIDTH        (16),
    .DEFAULT_HALF (25000)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_half     (cfg_half),
    .enable       (enable),
    .sync_restart (sync_restart),
    .clock_div    (clock_div),
    .tick         (tick),
    .pending      (pending)
  );

  typedef struct {
    logic [3:0]  en;
    logic        restart;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] half;
    logic [3:0]  div;
    logic [3:0]  tck;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [3:0] en, input logic rs, input logic we,
                     input logic [1:0] ch, input logic [15:0] half,
                     input logic [3:0] dv, input logic [3:0] tk, input logic [3:0] pd);
    vec_t v;
    v.en = en; v.restart = rs; v.we = we; v.ch = ch; v.half = half;
    v.div = dv; v.tck = tk; v.pend = pd;
    vecs.push_back(v);
  endtask

  // Default rate from reset release: nothing until edge 25001, then all toggle.
  task automatic run_default(input string tag, input bit do_write);
    int bad = 0;
    for (int n = 1; n <= 25000; n++) begin
      if (do_write && n == 100) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 16'd3;
      end
      step();
      cfg_we = 1'b0;
      if (clock_div !== 4'h0 || tick !== 4'h0 ||
          pending !== ((do_write && n >= 100) ? 4'b0010 : 4'b0000)) begin
        if (bad == 0)
          $display("FAIL %s_idle: cycle %0d div=%b tick=%b pend=%b", tag, n, clock_div, tick, pending);
        bad++;
      end
    end
    check({tag, "_idle_bad_cycles"}, bad, 0);
    step();
    check({tag, "_first_rise_div"}, clock_div, 4'hF);
    check({tag, "_first_rise_tick"}, tick, 4'hF);
    check({tag, "_first_rise_pend"}, pending, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
    enable = 4'h0; sync_restart = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("reset_div", clock_div, 4'h0);
    check("reset_tick", tick, 4'h0);
    check("reset_pend", pending, 4'h0);

    // Default rate plus ch1 T=3 written mid half-period
    #2 rst_n = 1'b1; enable = 4'hF;
    run_default("s1", 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("s2_div_k%0d", k), clock_div,
            {2'b11, (((k / 4) % 2) == 0) ? 1'b1 : 1'b0, 1'b1});
      check($sformatf("s2_tick_k%0d", k), tick, {2'b00, ((k % 4) == 0) ? 1'b1 : 1'b0, 1'b0});
    end

    // Load shadows: ch0 T=2, ch1 T=4, ch2 T=0, ch3 T=1 (applied by restart)
    for (int c = 0; c < 4; c++) begin
      cfg_we = 1'b1; cfg_ch = 2'(c);
      cfg_half = (c == 0) ? 16'd2 : (c == 1) ? 16'd4 : (c == 2) ? 16'd0 : 16'd1;
      step();
    end
    cfg_we = 1'b0;

    //  en     rs  we  ch  half   div      tick     pend
    add(4'hF, 1, 0, 0, 0,  4'b0000, 4'b0000, 4'b0000);  // restart
    add(4'hF, 0, 0, 0, 0,  4'b0100, 4'b0100, 4'b0000);  // k1
    add(4'hF, 0, 0, 0, 0,  4'b1000, 4'b1100, 4'b0000);  // k2
    add(4'hF, 0, 0, 0, 0,  4'b1101, 4'b0101, 4'b0000);  // k3
    add(4'hF, 0, 0, 0, 0,  4'b0001, 4'b1100, 4'b0000);  // k4
    add(4'hB, 0, 0, 0, 0,  4'b0011, 4'b0010, 4'b0000);  // k5 ch2 frozen
    add(4'hB, 0, 0, 0, 0,  4'b1010, 4'b1001, 4'b0000);  // k6
    add(4'hB, 0, 0, 0, 0,  4'b1010, 4'b0000, 4'b0000);  // k7
    add(4'hB, 0, 0, 0, 0,  4'b0010, 4'b1000, 4'b0000);  // k8
    add(4'hB, 0, 0, 0, 0,  4'b0011, 4'b0001, 4'b0000);  // k9
    add(4'hF, 0, 0, 0, 0,  4'b1101, 4'b1110, 4'b0000);  // k10 ch2 resumes
    add(4'hF, 0, 0, 0, 0,  4'b1001, 4'b0100, 4'b0000);  // k11
    add(4'hF, 0, 0, 0, 0,  4'b0100, 4'b1101, 4'b0000);  // k12
    add(4'hF, 0, 1, 0, 1,  4'b0000, 4'b0100, 4'b0001);  // k13 ch0 T=1 pending
    add(4'hF, 1, 1, 0, 3,  4'b0000, 4'b0000, 4'b0001);  // restart + write T=3
    add(4'hF, 0, 0, 0, 0,  4'b0100, 4'b0100, 4'b0001);  // k'1
    add(4'hF, 0, 0, 0, 0,  4'b1001, 4'b1101, 4'b0000);  // k'2 T=3 applied
    add(4'hF, 0, 0, 0, 0,  4'b1101, 4'b0100, 4'b0000);  // k'3
    add(4'hF, 0, 0, 0, 0,  4'b0001, 4'b1100, 4'b0000);  // k'4
    add(4'hF, 0, 0, 0, 0,  4'b0111, 4'b0110, 4'b0000);  // k'5
    add(4'hF, 0, 0, 0, 0,  4'b1010, 4'b1101, 4'b0000);  // k'6
    add(4'hF, 0, 1, 0, 5,  4'b1110, 4'b0100, 4'b0001);  // k'7 ch0 T=5
    add(4'hF, 0, 1, 0, 7,  4'b0010, 4'b1100, 4'b0001);  // k'8 ch0 T=7 wins
    add(4'hF, 0, 0, 0, 0,  4'b0110, 4'b0100, 4'b0001);  // k'9
    add(4'hF, 0, 0, 0, 0,  4'b1001, 4'b1111, 4'b0000);  // k'10 T=7 applied

    foreach (vecs[i]) begin
      enable = vecs[i].en; sync_restart = vecs[i].restart;
      cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_half = vecs[i].half;
      step();
      check($sformatf("vec%0d_div", i), clock_div, vecs[i].div);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].tck);
      check($sformatf("vec%0d_pend", i), pending, vecs[i].pend);
    end
    enable = 4'hF; sync_restart = 1'b0; cfg_we = 1'b0;

    // ch0 at T=7: write T=1 on its terminal edge, applied one half-period later
    for (int j = 11; j <= 30; j++) begin
      if (j == 18) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd1;
      end
      step();
      cfg_we = 1'b0;
      check($sformatf("s4_tick0_j%0d", j), tick[0],
            (j == 18 || j == 26 || j == 28 || j == 30) ? 1'b1 : 1'b0);
      check($sformatf("s4_div0_j%0d", j), clock_div[0],
            (j < 18 || j == 26 || j == 27 || j == 30) ? 1'b1 : 1'b0);
      check($sformatf("s4_pend0_j%0d", j), pending[0], (j >= 18 && j <= 25) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset between edges
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 16'd9;
    step();
    cfg_we = 1'b0;
    check("s6_pre_pend", pending, 4'b1000);
    check("s6_pre_div0", clock_div[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_div", clock_div, 4'h0);
    check("s6_async_tick", tick, 4'h0);
    check("s6_async_pend", pending, 4'h0);
    repeat (2) @(posedge clock);
    #3 rst_n = 1'b1;
    run_default("s6", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
